// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: shared bus constants, register map and trigger encodings for the interrupt controller.
package irq_ctrl_pkg;

  localparam int WORD_DATA_W = 32;

  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam int IRQ_CTRL_ADDR_W = 2;
  typedef logic [IRQ_CTRL_ADDR_W-1:0] IrqCtrlAddrBus;

  localparam IrqCtrlAddrBus IRQ_CTRL_ADDR_STATUS = 2'h0;
  localparam IrqCtrlAddrBus IRQ_CTRL_ADDR_MASK   = 2'h1;
  localparam IrqCtrlAddrBus IRQ_CTRL_ADDR_TRIG   = 2'h2;
  localparam IrqCtrlAddrBus IRQ_CTRL_ADDR_VECTOR = 2'h3;

  localparam logic IRQ_TRIG_LEVEL = 1'b0;
  localparam logic IRQ_TRIG_EDGE  = 1'b1;

  localparam int IrqVldLoc = 31;

endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// irq_prio_enc: combinational lowest-index-first encoder; o_vld is set when any request is active.
module irq_prio_enc #(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = 3
) (
  input  logic [NUM_IRQ-1:0] i_req,
  output logic               o_vld,
  output logic [IDX_W-1:0]   o_idx
);

  // Scan from the top so the lowest active index is the last one written.
  always_comb begin
    o_vld = 1'b0;
    o_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      o_vld = i_req[i] ? 1'b1 : o_vld;
      o_idx = i_req[i] ? IDX_W'(i) : o_idx;
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: latches request lines into pending bits, applies mask and level/edge select, drives cpu_irq and a vector.
// Define IRQ_CTRL_SYNC_EN to pass irq_in through a 2-flop synchronizer (input-to-cpu_irq latency 4 instead of 2).
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cs_,
  input  logic                   as_,
  input  logic                   rw,
  input  IrqCtrlAddrBus          addr,
  input  logic [WORD_DATA_W-1:0] wr_data,
  output logic [WORD_DATA_W-1:0] rd_data,
  output logic                   rdy_,
  input  logic [NUM_IRQ-1:0]     irq_in,
  output logic                   cpu_irq
);

  logic [NUM_IRQ-1:0]     r_pending, r_mask, r_trig, r_irq_q;
  logic [NUM_IRQ-1:0]     w_src, w_set, w_clr, w_active;
  logic                   w_bus, w_wr, w_vld;
  logic [IDX_W-1:0]       w_idx;
  logic [WORD_DATA_W-1:0] w_vector, w_rd;
  logic                   w_unused_wr_hi;

`ifdef IRQ_CTRL_SYNC_EN
  logic [NUM_IRQ-1:0] r_sync1, r_sync2;

  // Two-stage synchronizer for asynchronous request sources.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_src = r_sync2;
`else
  assign w_src = irq_in;
`endif

  assign w_bus          = ~cs_ & ~as_;
  assign w_wr           = w_bus & (rw == WRITE);
  assign w_active       = r_pending & ~r_mask;
  assign w_unused_wr_hi = ^wr_data[WORD_DATA_W-1:NUM_IRQ];

  // Edge sources set only on a rising sample; level sources set whenever high.
  always_comb begin
    w_set = (r_trig & w_src & ~r_irq_q) | (~r_trig & w_src);
    if (w_wr && (addr == IRQ_CTRL_ADDR_STATUS)) begin
      w_clr = wr_data[NUM_IRQ-1:0];
    end else begin
      w_clr = '0;
    end
  end

  irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .IDX_W   (IDX_W)
  ) u_prio_enc (
    .i_req (w_active),
    .o_vld (w_vld),
    .o_idx (w_idx)
  );

  // Register read mux; unimplemented bits stay zero.
  always_comb begin
    w_vector            = '0;
    w_vector[IrqVldLoc] = w_vld;
    w_vector[IDX_W-1:0] = w_idx;
    w_rd                = '0;
    case (addr)
      IRQ_CTRL_ADDR_STATUS: w_rd[NUM_IRQ-1:0] = r_pending;
      IRQ_CTRL_ADDR_MASK:   w_rd[NUM_IRQ-1:0] = r_mask;
      IRQ_CTRL_ADDR_TRIG:   w_rd[NUM_IRQ-1:0] = r_trig;
      IRQ_CTRL_ADDR_VECTOR: w_rd = w_vector;
      default:              w_rd = '0;
    endcase
  end

  // Pending/mask/trigger state, input sample and registered bus/irq outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pending <= '0;
      r_mask    <= '1;
      r_trig    <= '0;
      r_irq_q   <= '0;
      cpu_irq   <= 1'b0;
      rd_data   <= '0;
      rdy_      <= DISABLE_;
    end else begin
      r_irq_q   <= w_src;
      r_pending <= (r_pending & ~w_clr) | w_set;
      cpu_irq   <= |w_active;
      if (w_wr) begin
        case (addr)
          IRQ_CTRL_ADDR_MASK: r_mask <= wr_data[NUM_IRQ-1:0];
          IRQ_CTRL_ADDR_TRIG: r_trig <= wr_data[NUM_IRQ-1:0];
          default:            r_mask <= r_mask;
        endcase
      end else begin
        r_mask <= r_mask;
      end
      rd_data <= (w_bus && (rw == READ)) ? w_rd : '0;
      rdy_    <= w_bus ? ENABLE_ : DISABLE_;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scenarios plus randomized traffic checked against a behavioural model of irq_ctrl.
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  localparam int N = 8;
`ifdef IRQ_CTRL_SYNC_EN
  localparam int LAT    = 4;
  localparam int SYNC_D = 2;
`else
  localparam int LAT    = 2;
  localparam int SYNC_D = 0;
`endif

  logic        clk = 1'b0;
  logic        reset, cs_, as_, rw, rdy_, cpu_irq;
  logic [1:0]  addr;
  logic [31:0] wr_data, rd_data;
  logic [N-1:0] irq_in;

  int checks   = 0;
  int failures = 0;

  logic [N-1:0] m_pend = '0, m_mask = '0, m_trig = '0, m_q = '0, m_s1 = '0, m_s2 = '0;
  logic         m_cpu = 1'b0, m_rdy = 1'b1;
  logic [31:0]  m_rd = 32'h0;

  irq_ctrl #(.NUM_IRQ(N), .IDX_W(3)) dut (
    .clk(clk), .reset(reset), .cs_(cs_), .as_(as_), .rw(rw), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .rdy_(rdy_), .irq_in(irq_in), .cpu_irq(cpu_irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] vec_of(input logic [N-1:0] act);
    logic found;
    vec_of = 32'h0;
    found  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (act[i] && !found) begin
        vec_of = 32'h8000_0000 + i;
        found  = 1'b1;
      end
    end
  endfunction

  // Reference model: one clock edge applied to the spec-level register state.
  task automatic model_edge();
    logic [N-1:0] src, set, clr, act;
    logic [31:0]  rdv;
    logic         bus;
`ifdef IRQ_CTRL_SYNC_EN
    src = m_s2;
`else
    src = irq_in;
`endif
    for (int i = 0; i < N; i++) set[i] = m_trig[i] ? (src[i] && !m_q[i]) : src[i];
    act = m_pend & ~m_mask;
    bus = !cs_ && !as_;
    clr = (bus && rw == WRITE && addr == 2'd0) ? wr_data[N-1:0] : '0;
    case (addr)
      2'd0:    rdv = {24'h0, m_pend};
      2'd1:    rdv = {24'h0, m_mask};
      2'd2:    rdv = {24'h0, m_trig};
      default: rdv = vec_of(act);
    endcase
    if (!reset) begin
      m_pend = '0; m_mask = {N{1'b1}}; m_trig = '0; m_q = '0; m_s1 = '0; m_s2 = '0;
      m_cpu = 1'b0; m_rd = 32'h0; m_rdy = 1'b1;
    end else begin
      m_rd  = (bus && rw == READ) ? rdv : 32'h0;
      m_rdy = !bus;
      m_cpu = (act != '0);
      m_pend = (m_pend & ~clr) | set;
      if (bus && rw == WRITE && addr == 2'd1) m_mask = wr_data[N-1:0];
      if (bus && rw == WRITE && addr == 2'd2) m_trig = wr_data[N-1:0];
      m_s2 = m_s1;
      m_s1 = irq_in;
      m_q  = src;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    cs_ = 1'b0; as_ = 1'b0; rw = WRITE; addr = a; wr_data = d;
    cycle();
    cs_ = 1'b1; as_ = 1'b1; rw = READ; wr_data = 32'h0;
  endtask

  task automatic bus_rd(input logic [1:0] a);
    cs_ = 1'b0; as_ = 1'b0; rw = READ; addr = a;
    cycle();
    cs_ = 1'b1; as_ = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] exp_rd [4];
    exp_rd[0] = 32'h0; exp_rd[1] = 32'hFF; exp_rd[2] = 32'h0; exp_rd[3] = 32'h0;
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    checks++;
    if (cpu_irq !== 1'b0 || rdy_ !== 1'b1 || rd_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs: got cpu_irq=%b rdy_=%b rd_data=%h expected 0/1/0", cpu_irq, rdy_, rd_data);
    end
    for (int a = 0; a < 4; a++) begin
      bus_rd(2'(a));
      checks++;
      if (rd_data !== exp_rd[a] || rdy_ !== 1'b0) begin
        failures++;
        $display("FAIL reset_reg%0d: got %h rdy_=%b expected %h rdy_=0", a, rd_data, rdy_, exp_rd[a]);
      end
    end
  endtask

  task automatic test_level();
    int lat;
    bus_wr(2'd1, 32'hFE);
    irq_in = 8'h01;
    lat = 0;
    do begin
      cycle();
      lat++;
    end while (cpu_irq !== 1'b1 && lat < 10);
    checks++;
    if (lat != LAT) begin
      failures++;
      $display("FAIL level_latency: got %0d cycles expected %0d", lat, LAT);
    end
    bus_rd(2'd0);
    checks++;
    if (rd_data !== 32'h01) begin
      failures++;
      $display("FAIL level_status: got %h expected 00000001", rd_data);
    end
    bus_rd(2'd3);
    checks++;
    if (rd_data !== 32'h8000_0000 || cpu_irq !== 1'b1) begin
      failures++;
      $display("FAIL level_vector: got %h cpu_irq=%b expected 80000000 cpu_irq=1", rd_data, cpu_irq);
    end
  endtask

  task automatic test_level_hold();
    bus_wr(2'd0, 32'h01);
    bus_rd(2'd0);
    checks++;
    if (rd_data !== 32'h01) begin
      failures++;
      $display("FAIL hold_repend: got %h expected 00000001", rd_data);
    end
    irq_in = 8'h00;
    idle(LAT);
    bus_wr(2'd0, 32'h01);
    checks++;
    if (cpu_irq !== 1'b1) begin
      failures++;
      $display("FAIL hold_clr_lat1: got cpu_irq=%b expected 1", cpu_irq);
    end
    cycle();
    checks++;
    if (cpu_irq !== 1'b0) begin
      failures++;
      $display("FAIL hold_clr_lat2: got cpu_irq=%b expected 0", cpu_irq);
    end
  endtask

  task automatic test_edge();
    bus_wr(2'd2, 32'h04);
    bus_wr(2'd1, 32'h00);
    irq_in = 8'h04;
    cycle();
    irq_in = 8'h00;
    idle(4);
    bus_rd(2'd0);
    checks++;
    if (rd_data !== 32'h04) begin
      failures++;
      $display("FAIL edge_pulse: got %h expected 00000004", rd_data);
    end
    irq_in = 8'h04;
    idle(4);
    bus_wr(2'd0, 32'h04);
    idle(3);
    bus_rd(2'd0);
    checks++;
    if (rd_data !== 32'h00) begin
      failures++;
      $display("FAIL edge_held_no_reset: got %h expected 00000000", rd_data);
    end
    irq_in = 8'h00;
    idle(LAT);
  endtask

  task automatic test_priority();
    bus_wr(2'd2, 32'h00);
    irq_in = 8'h0A;
    cycle();
    irq_in = 8'h00;
    idle(4);
    bus_wr(2'd1, 32'h02);
    bus_rd(2'd0);
    checks++;
    if (rd_data !== 32'h0A) begin
      failures++;
      $display("FAIL prio_status: got %h expected 0000000a", rd_data);
    end
    bus_rd(2'd3);
    checks++;
    if (rd_data !== 32'h8000_0003) begin
      failures++;
      $display("FAIL prio_vec_masked: got %h expected 80000003", rd_data);
    end
    bus_wr(2'd1, 32'h00);
    bus_rd(2'd3);
    checks++;
    if (rd_data !== 32'h8000_0001) begin
      failures++;
      $display("FAIL prio_vec_unmasked: got %h expected 80000001", rd_data);
    end
  endtask

  task automatic test_collision();
    bus_wr(2'd0, 32'hFF);
    bus_wr(2'd2, 32'h04);
    irq_in = 8'h04;
    cycle();
    irq_in = 8'h00;
    idle(4);
    irq_in = 8'h04;
    idle(SYNC_D);
    bus_wr(2'd0, 32'h04);
    bus_rd(2'd0);
    checks++;
    if (rd_data !== 32'h04) begin
      failures++;
      $display("FAIL collision_set_wins: got %h expected 00000004", rd_data);
    end
    irq_in = 8'h00;
    idle(LAT);
  endtask

  task automatic test_reset_mid();
    cs_ = 1'b0; as_ = 1'b0; rw = READ; addr = 2'd1; reset = 1'b0;
    cycle();
    reset = 1'b1; cs_ = 1'b1; as_ = 1'b1;
    checks++;
    if (rdy_ !== 1'b1 || rd_data !== 32'h0 || cpu_irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_read: got rdy_=%b rd_data=%h cpu_irq=%b expected 1/0/0", rdy_, rd_data, cpu_irq);
    end
    bus_rd(2'd1);
    checks++;
    if (rd_data !== 32'hFF) begin
      failures++;
      $display("FAIL reset_mid_mask: got %h expected 000000ff", rd_data);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset   = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      cs_     = ($urandom_range(0, 3) == 0);
      as_     = ($urandom_range(0, 3) == 0);
      rw      = ($urandom_range(0, 2) == 0) ? WRITE : READ;
      addr    = 2'($urandom_range(0, 3));
      wr_data = $urandom;
      irq_in  = N'($urandom & $urandom);
      cycle();
      checks++;
      if (cpu_irq !== m_cpu || rdy_ !== m_rdy || rd_data !== m_rd) begin
        failures++;
        $display("FAIL random_c%0d: got cpu_irq=%b rdy_=%b rd=%h expected %b/%b/%h",
                 c, cpu_irq, rdy_, rd_data, m_cpu, m_rdy, m_rd);
      end
    end
    reset = 1'b1; cs_ = 1'b1; as_ = 1'b1; irq_in = '0;
  endtask

  initial begin
    reset = 1'b0; cs_ = 1'b1; as_ = 1'b1; rw = READ; addr = 2'd0;
    wr_data = 32'h0; irq_in = '0;
    test_reset();
    test_level();
    test_level_hold();
    test_edge();
    test_priority();
    test_collision();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
